// File: rtl/amber48_pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : amber48_pipe_ctrl_if
//  Description : Signal bundle between the amber48 decode/execute/LSU stages
//                and the pipeline hazard/control sequencer.
//                master : the core side (drives stage fields, consumes controls)
//                slave  : the sequencer (consumes stage fields, drives controls)
//  Ports       : ID fields   id_valid, id_rs1, id_rs2, id_rd, id_uses_rs2,
//                            id_writes, id_load
//                EX fields   ex_valid, ex_rd, ex_writeback_en, ex_load,
//                            ex_branch_taken, ex_branch_target, ex_trap,
//                            ex_trap_cause, ex_pc
//                LSU         lsu_wb_valid, lsu_wb_rd
//                Controls    stall_if, stall_id, flush_id, flush_ex,
//                            redirect_valid, redirect_pc, trap_active,
//                            epc, cause, loads_pending
//  Revision    : 1.0  initial release
// ============================================================================
interface amber48_pipe_ctrl_if #(
  parameter int MAX_LOADS = 2
) ();
  localparam int CW = $clog2(MAX_LOADS + 1);

  // Decode stage
  logic          id_valid;
  logic [3:0]    id_rs1;
  logic [3:0]    id_rs2;
  logic [3:0]    id_rd;
  logic          id_uses_rs2;
  logic          id_writes;
  logic          id_load;

  // Execute stage
  logic          ex_valid;
  logic [3:0]    ex_rd;
  logic          ex_writeback_en;
  logic          ex_load;
  logic          ex_branch_taken;
  logic [47:0]   ex_branch_target;
  logic          ex_trap;
  logic [2:0]    ex_trap_cause;
  logic [47:0]   ex_pc;

  // Load writeback
  logic          lsu_wb_valid;
  logic [3:0]    lsu_wb_rd;

  // Controls
  logic          stall_if;
  logic          stall_id;
  logic          flush_id;
  logic          flush_ex;
  logic          redirect_valid;
  logic [47:0]   redirect_pc;
  logic          trap_active;
  logic [47:0]   epc;
  logic [2:0]    cause;
  logic [CW-1:0] loads_pending;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_uses_rs2, id_writes, id_load,
    output ex_valid, ex_rd, ex_writeback_en, ex_load, ex_branch_taken,
    output ex_branch_target, ex_trap, ex_trap_cause, ex_pc,
    output lsu_wb_valid, lsu_wb_rd,
    input  stall_if, stall_id, flush_id, flush_ex, redirect_valid,
    input  redirect_pc, trap_active, epc, cause, loads_pending
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_uses_rs2, id_writes, id_load,
    input  ex_valid, ex_rd, ex_writeback_en, ex_load, ex_branch_taken,
    input  ex_branch_target, ex_trap, ex_trap_cause, ex_pc,
    input  lsu_wb_valid, lsu_wb_rd,
    output stall_if, stall_id, flush_id, flush_ex, redirect_valid,
    output redirect_pc, trap_active, epc, cause, loads_pending
  );
endinterface
`default_nettype wire

// File: rtl/amber48_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : amber48_pipe_ctrl
//  Description : Hazard and control sequencer for the amber48 five-stage core.
//                Keeps a scoreboard of registers with loads in flight, limits
//                the number of outstanding loads, produces IF/ID/EX stall and
//                flush controls, and folds taken branches and traps into one
//                PC redirect toward the fetch unit.
//  Ports       : clk    core clock, rising-edge state updates
//                rst_n  asynchronous active-low reset
//                bus    amber48_pipe_ctrl_if.slave (stage fields in,
//                       stall/flush/redirect/trap status out)
//  Revision    : 1.0  initial release
// ============================================================================
module amber48_pipe_ctrl #(
  parameter int          MAX_LOADS   = 2,
  parameter logic [47:0] TRAP_VECTOR = 48'h0
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  amber48_pipe_ctrl_if.slave    bus
);
  localparam int CW = $clog2(MAX_LOADS + 1);

  localparam logic [1:0] c_st_run      = 2'd0;
  localparam logic [1:0] c_st_drain    = 2'd1;
  localparam logic [1:0] c_st_redirect = 2'd2;

  localparam logic [2:0] c_trap_none   = 3'd0;

  localparam logic [CW:0] c_max_loads  = (CW + 1)'(MAX_LOADS);

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [15:0]   r_pend;
  logic [15:0]   w_pend_nxt;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic [47:0]   r_epc;
  logic [2:0]    r_cause;

  logic          w_run;
  logic          w_ld_iss;
  logic          w_trap_take;
  logic          w_branch_take;
  logic          w_busy_rs1;
  logic          w_busy_rs2;
  logic          w_busy_rd;
  logic          w_raw_hazard;
  logic [CW:0]   w_count_eff;
  logic          w_limit_hazard;
  logic          w_hazard;

  assign w_run         = (r_state == c_st_run);
  assign w_ld_iss      = w_run & bus.ex_valid & bus.ex_load & bus.ex_writeback_en & ~bus.ex_trap;
  assign w_trap_take   = w_run & bus.ex_valid & bus.ex_trap;
  assign w_branch_take = w_run & bus.ex_valid & bus.ex_branch_taken & ~bus.ex_trap;

  // A register is busy if a load to it is already in flight or is issuing
  // from EX right now (the scoreboard bit only appears next cycle).
  assign w_busy_rs1 = (bus.id_rs1 != 4'd0) &
                      (r_pend[bus.id_rs1] | (w_ld_iss & (bus.id_rs1 == bus.ex_rd)));
  assign w_busy_rs2 = (bus.id_rs2 != 4'd0) &
                      (r_pend[bus.id_rs2] | (w_ld_iss & (bus.id_rs2 == bus.ex_rd)));
  assign w_busy_rd  = (bus.id_rd != 4'd0) &
                      (r_pend[bus.id_rd] | (w_ld_iss & (bus.id_rd == bus.ex_rd)));

  assign w_raw_hazard = w_run & bus.id_valid &
                        (w_busy_rs1 | (bus.id_uses_rs2 & w_busy_rs2) | (bus.id_writes & w_busy_rd));

  // Count the load issuing this cycle too, so a second load cannot slip in
  // behind one that has not reached the counter yet.
  assign w_count_eff    = {1'b0, r_count} + {{CW{1'b0}}, w_ld_iss};
  assign w_limit_hazard = w_run & bus.id_valid & bus.id_load & (w_count_eff >= c_max_loads);
  assign w_hazard       = w_raw_hazard | w_limit_hazard;

  // Scoreboard: issue sets, writeback clears; an issue to the same register
  // in the same cycle wins. r0 is hard-wired clear.
  always_comb begin
    w_pend_nxt = r_pend;
    if (bus.lsu_wb_valid) begin
      w_pend_nxt[bus.lsu_wb_rd] = 1'b0;
    end
    if (w_ld_iss) begin
      w_pend_nxt[bus.ex_rd] = 1'b1;
    end
    w_pend_nxt[0] = 1'b0;
  end

  // Outstanding-load counter; a writeback with nothing in flight is ignored.
  always_comb begin
    w_count_nxt = r_count;
    if (w_ld_iss && !bus.lsu_wb_valid) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_ld_iss && bus.lsu_wb_valid && (r_count != '0)) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend  <= '0;
      r_count <= '0;
      r_epc   <= '0;
      r_cause <= c_trap_none;
    end else begin
      r_pend  <= w_pend_nxt;
      r_count <= w_count_nxt;
      if (w_trap_take) begin
        r_epc   <= bus.ex_pc;
        r_cause <= bus.ex_trap_cause;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_run;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state; DRAIN waits on the registered count so every load
  // in flight at the trap has written back before the redirect.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_run: begin
        if (w_trap_take) begin
          w_state_nxt = c_st_drain;
        end
      end
      c_st_drain: begin
        if (r_count == '0) begin
          w_state_nxt = c_st_redirect;
        end
      end
      c_st_redirect: begin
        w_state_nxt = c_st_run;
      end
      default: begin
        w_state_nxt = c_st_run;
      end
    endcase
  end

  // FSM outputs; in RUN the priority is trap > taken branch > hazard.
  always_comb begin
    bus.stall_if       = 1'b0;
    bus.stall_id       = 1'b0;
    bus.flush_id       = 1'b0;
    bus.flush_ex       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.trap_active    = 1'b0;
    case (r_state)
      c_st_run: begin
        if (w_trap_take) begin
          bus.stall_if = 1'b1;
          bus.flush_id = 1'b1;
          bus.flush_ex = 1'b1;
        end else if (w_branch_take) begin
          bus.redirect_valid = 1'b1;
          bus.redirect_pc    = bus.ex_branch_target;
          bus.flush_id       = 1'b1;
          bus.flush_ex       = 1'b1;
        end else if (w_hazard) begin
          bus.stall_if = 1'b1;
          bus.stall_id = 1'b1;
          bus.flush_ex = 1'b1;
        end
      end
      c_st_drain: begin
        bus.trap_active = 1'b1;
        bus.stall_if    = 1'b1;
        bus.flush_id    = 1'b1;
        bus.flush_ex    = 1'b1;
      end
      c_st_redirect: begin
        bus.trap_active    = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = TRAP_VECTOR;
        bus.flush_id       = 1'b1;
        bus.flush_ex       = 1'b1;
      end
      default: begin
        bus.stall_if = 1'b0;
      end
    endcase
  end

  assign bus.epc           = r_epc;
  assign bus.cause         = r_cause;
  assign bus.loads_pending = r_count;

endmodule
`default_nettype wire

// File: tb/tb_amber48_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_amber48_pipe_ctrl
//  Description : Directed self-checking bench for amber48_pipe_ctrl.
//                Inputs change 1 time unit after a rising edge, outputs are
//                sampled 2 time units after it.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_amber48_pipe_ctrl;
  localparam logic [47:0] c_tv         = 48'h0000_0000_ABC0;
  localparam logic [2:0]  c_illegal    = 3'd1;
  localparam logic [2:0]  c_data_fault = 3'd2;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;

  amber48_pipe_ctrl_if #(.MAX_LOADS(2)) bus ();

  amber48_pipe_ctrl #(
    .MAX_LOADS   (2),
    .TRAP_VECTOR (c_tv)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0;
    bus.id_uses_rs2 = 0; bus.id_writes = 0; bus.id_load = 0;
    bus.ex_valid = 0; bus.ex_rd = 0; bus.ex_writeback_en = 0; bus.ex_load = 0;
    bus.ex_branch_taken = 0; bus.ex_branch_target = 0; bus.ex_trap = 0;
    bus.ex_trap_cause = 0; bus.ex_pc = 0;
    bus.lsu_wb_valid = 0; bus.lsu_wb_rd = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_load_to(input logic [3:0] rd);
    bus.ex_valid = 1; bus.ex_load = 1; bus.ex_writeback_en = 1; bus.ex_rd = rd;
  endtask

  task automatic ex_clear();
    bus.ex_valid = 0; bus.ex_load = 0; bus.ex_writeback_en = 0; bus.ex_rd = 0;
    bus.ex_branch_taken = 0; bus.ex_trap = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #12;
    rst_n = 1;
    tick();
    #1;
    n_total++;
    if ({bus.stall_if, bus.stall_id, bus.flush_id, bus.flush_ex, bus.redirect_valid, bus.trap_active} !== 6'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 000000",
        {bus.stall_if, bus.stall_id, bus.flush_id, bus.flush_ex, bus.redirect_valid, bus.trap_active});
    end
    n_total++;
    if (bus.redirect_pc !== 48'h0 || bus.epc !== 48'h0 || bus.cause !== 3'd0 || bus.loads_pending !== 2'd0) begin
      n_bad++; $display("FAIL reset_regs: pc=%h epc=%h cause=%0d pend=%0d want all 0",
        bus.redirect_pc, bus.epc, bus.cause, bus.loads_pending);
    end
  endtask

  task automatic test_load_use();
    tick();
    ex_load_to(4'd3);
    bus.id_valid = 1; bus.id_rs1 = 4'd3;
    #1;
    n_total++;
    if ({bus.stall_if, bus.stall_id, bus.flush_id, bus.flush_ex} !== 4'b1101) begin
      n_bad++; $display("FAIL load_use_issue: got %b want 1101",
        {bus.stall_if, bus.stall_id, bus.flush_id, bus.flush_ex});
    end
    tick();
    ex_clear();
    #1;
    n_total++;
    if (bus.stall_id !== 1'b1 || bus.loads_pending !== 2'd1) begin
      n_bad++; $display("FAIL load_use_pending: stall_id=%b pend=%0d want 1 1", bus.stall_id, bus.loads_pending);
    end
    tick();
    bus.lsu_wb_valid = 1; bus.lsu_wb_rd = 4'd3;
    #1;
    n_total++;
    if (bus.stall_id !== 1'b1) begin
      n_bad++; $display("FAIL load_use_wb_cycle: stall_id=%b want 1", bus.stall_id);
    end
    tick();
    bus.lsu_wb_valid = 0;
    #1;
    n_total++;
    if (bus.stall_id !== 1'b0 || bus.stall_if !== 1'b0 || bus.loads_pending !== 2'd0) begin
      n_bad++; $display("FAIL load_use_release: stall_id=%b stall_if=%b pend=%0d want 0 0 0",
        bus.stall_id, bus.stall_if, bus.loads_pending);
    end
    idle_inputs();
  endtask

  task automatic test_r0();
    tick();
    ex_load_to(4'd0);
    bus.id_valid = 1; bus.id_rs1 = 4'd0; bus.id_writes = 1; bus.id_rd = 4'd0;
    #1;
    n_total++;
    if (bus.stall_id !== 1'b0) begin
      n_bad++; $display("FAIL r0_no_hazard: stall_id=%b want 0", bus.stall_id);
    end
    tick();
    ex_clear();
    #1;
    n_total++;
    if (bus.stall_id !== 1'b0 || bus.loads_pending !== 2'd1) begin
      n_bad++; $display("FAIL r0_counted: stall_id=%b pend=%0d want 0 1", bus.stall_id, bus.loads_pending);
    end
    bus.lsu_wb_valid = 1; bus.lsu_wb_rd = 4'd0;
    tick();
    tick();
    #1;
    n_total++;
    if (bus.loads_pending !== 2'd0) begin
      n_bad++; $display("FAIL no_underflow: pend=%0d want 0", bus.loads_pending);
    end
    idle_inputs();
  endtask

  task automatic test_load_limit();
    tick();
    ex_load_to(4'd4);
    tick();
    ex_load_to(4'd5);
    bus.id_valid = 1; bus.id_load = 1; bus.id_writes = 1; bus.id_rd = 4'd6;
    #1;
    n_total++;
    if (bus.stall_id !== 1'b1) begin
      n_bad++; $display("FAIL limit_inflight: stall_id=%b want 1", bus.stall_id);
    end
    tick();
    ex_clear();
    #1;
    n_total++;
    if (bus.stall_id !== 1'b1 || bus.loads_pending !== 2'd2) begin
      n_bad++; $display("FAIL limit_full: stall_id=%b pend=%0d want 1 2", bus.stall_id, bus.loads_pending);
    end
    bus.lsu_wb_valid = 1; bus.lsu_wb_rd = 4'd4;
    tick();
    bus.lsu_wb_valid = 0;
    #1;
    n_total++;
    if (bus.stall_id !== 1'b0 || bus.loads_pending !== 2'd1) begin
      n_bad++; $display("FAIL limit_release: stall_id=%b pend=%0d want 0 1", bus.stall_id, bus.loads_pending);
    end
    bus.id_valid = 0; bus.id_load = 0;
    bus.lsu_wb_valid = 1; bus.lsu_wb_rd = 4'd5;
    tick();
    bus.lsu_wb_valid = 0;
    idle_inputs();
  endtask

  task automatic test_branch_over_hazard();
    tick();
    ex_load_to(4'd7);
    tick();
    ex_clear();
    bus.id_valid = 1; bus.id_rs2 = 4'd7; bus.id_uses_rs2 = 1;
    #1;
    n_total++;
    if (bus.stall_id !== 1'b1) begin
      n_bad++; $display("FAIL rs2_hazard: stall_id=%b want 1", bus.stall_id);
    end
    bus.ex_valid = 1; bus.ex_branch_taken = 1; bus.ex_branch_target = 48'h100;
    #1;
    n_total++;
    if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 48'h100) begin
      n_bad++; $display("FAIL branch_redirect: valid=%b pc=%h want 1 100", bus.redirect_valid, bus.redirect_pc);
    end
    n_total++;
    if ({bus.stall_if, bus.stall_id, bus.flush_id, bus.flush_ex} !== 4'b0011) begin
      n_bad++; $display("FAIL branch_ctrl: got %b want 0011",
        {bus.stall_if, bus.stall_id, bus.flush_id, bus.flush_ex});
    end
    tick();
    idle_inputs();
    bus.lsu_wb_valid = 1; bus.lsu_wb_rd = 4'd7;
    tick();
    bus.lsu_wb_valid = 0;
    #1;
    n_total++;
    if (bus.loads_pending !== 2'd0 || bus.redirect_valid !== 1'b0) begin
      n_bad++; $display("FAIL branch_after: pend=%0d rv=%b want 0 0", bus.loads_pending, bus.redirect_valid);
    end
  endtask

  task automatic test_trap_drain();
    tick();
    ex_load_to(4'd2);
    tick();
    ex_clear();
    bus.ex_valid = 1; bus.ex_trap = 1; bus.ex_pc = 48'h40; bus.ex_trap_cause = c_data_fault;
    #1;
    n_total++;
    if ({bus.stall_if, bus.stall_id, bus.flush_id, bus.flush_ex, bus.redirect_valid, bus.trap_active} !== 6'b101100) begin
      n_bad++; $display("FAIL trap_cycle: got %b want 101100",
        {bus.stall_if, bus.stall_id, bus.flush_id, bus.flush_ex, bus.redirect_valid, bus.trap_active});
    end
    tick();  // T+1
    bus.ex_valid = 0; bus.ex_trap = 0; bus.ex_pc = 0; bus.ex_trap_cause = 0;
    ex_load_to(4'd9);  // ignored while draining
    #1;
    n_total++;
    if ({bus.stall_if, bus.flush_id, bus.flush_ex, bus.trap_active, bus.redirect_valid} !== 5'b11110) begin
      n_bad++; $display("FAIL drain_ctrl: got %b want 11110",
        {bus.stall_if, bus.flush_id, bus.flush_ex, bus.trap_active, bus.redirect_valid});
    end
    tick();  // T+2
    ex_clear();
    tick();  // T+3
    bus.lsu_wb_valid = 1; bus.lsu_wb_rd = 4'd2;
    #1;
    n_total++;
    if (bus.trap_active !== 1'b1 || bus.loads_pending !== 2'd1) begin
      n_bad++; $display("FAIL drain_wait: trap_active=%b pend=%0d want 1 1", bus.trap_active, bus.loads_pending);
    end
    tick();  // T+4
    bus.lsu_wb_valid = 0;
    #1;
    n_total++;
    if (bus.redirect_valid !== 1'b0 || bus.trap_active !== 1'b1 || bus.loads_pending !== 2'd0) begin
      n_bad++; $display("FAIL drain_last: rv=%b ta=%b pend=%0d want 0 1 0",
        bus.redirect_valid, bus.trap_active, bus.loads_pending);
    end
    tick();  // T+5
    #1;
    n_total++;
    if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== c_tv || bus.stall_if !== 1'b0 || bus.flush_id !== 1'b1) begin
      n_bad++; $display("FAIL trap_redirect: rv=%b pc=%h sif=%b fid=%b want 1 %h 0 1",
        bus.redirect_valid, bus.redirect_pc, bus.stall_if, bus.flush_id, c_tv);
    end
    tick();  // T+6
    #1;
    n_total++;
    if (bus.trap_active !== 1'b0 || bus.redirect_valid !== 1'b0 || bus.epc !== 48'h40 || bus.cause !== c_data_fault) begin
      n_bad++; $display("FAIL trap_done: ta=%b rv=%b epc=%h cause=%0d want 0 0 40 %0d",
        bus.trap_active, bus.redirect_valid, bus.epc, bus.cause, c_data_fault);
    end
    idle_inputs();
  endtask

  task automatic test_trap_branch();
    tick();
    bus.ex_valid = 1; bus.ex_trap = 1; bus.ex_branch_taken = 1;
    bus.ex_branch_target = 48'h200; bus.ex_pc = 48'h80; bus.ex_trap_cause = c_illegal;
    #1;
    n_total++;
    if (bus.redirect_valid !== 1'b0 || bus.redirect_pc !== 48'h0 || bus.flush_ex !== 1'b1) begin
      n_bad++; $display("FAIL trap_beats_branch: rv=%b pc=%h fex=%b want 0 0 1",
        bus.redirect_valid, bus.redirect_pc, bus.flush_ex);
    end
    tick();
    idle_inputs();
    #1;
    n_total++;
    if (bus.trap_active !== 1'b1 || bus.redirect_valid !== 1'b0 || bus.epc !== 48'h80 || bus.cause !== c_illegal) begin
      n_bad++; $display("FAIL trap_branch_drain: ta=%b rv=%b epc=%h cause=%0d want 1 0 80 %0d",
        bus.trap_active, bus.redirect_valid, bus.epc, bus.cause, c_illegal);
    end
    tick();
    #1;
    n_total++;
    if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== c_tv) begin
      n_bad++; $display("FAIL trap_branch_redirect: rv=%b pc=%h want 1 %h", bus.redirect_valid, bus.redirect_pc, c_tv);
    end
    tick();
  endtask

  task automatic test_reset_mid_drain();
    tick();
    ex_load_to(4'd1);
    tick();
    ex_load_to(4'd2);
    tick();
    ex_clear();
    bus.ex_valid = 1; bus.ex_trap = 1; bus.ex_pc = 48'hC4; bus.ex_trap_cause = c_illegal;
    tick();
    idle_inputs();
    #1;
    n_total++;
    if (bus.trap_active !== 1'b1 || bus.loads_pending !== 2'd2) begin
      n_bad++; $display("FAIL pre_reset_drain: ta=%b pend=%0d want 1 2", bus.trap_active, bus.loads_pending);
    end
    #1;
    rst_n = 0;
    #1;
    n_total++;
    if ({bus.trap_active, bus.stall_if, bus.stall_id, bus.flush_id, bus.flush_ex, bus.redirect_valid} !== 6'b0 ||
        bus.loads_pending !== 2'd0 || bus.epc !== 48'h0) begin
      n_bad++; $display("FAIL async_reset: ctrl=%b pend=%0d epc=%h want 000000 0 0",
        {bus.trap_active, bus.stall_if, bus.stall_id, bus.flush_id, bus.flush_ex, bus.redirect_valid},
        bus.loads_pending, bus.epc);
    end
    #3;
    rst_n = 1;
    tick();
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1;
    idle_inputs();
    test_reset();
    test_load_use();
    test_r0();
    test_load_limit();
    test_branch_over_hazard();
    test_trap_drain();
    test_trap_branch();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: sim time exceeded, want completion");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
